// File: rtl/mcu_scheduler.sv
// MCU scheduler: walks the MCU grid of a picture, issuing one MCU at a time when a camera strip
// and a downstream slot are both available, and tags each MCU with row/picture/restart flags.
module mcu_scheduler #(
    parameter int W_PW     = 11,
    parameter int W_PH     = 10,
    parameter int N_STRIPS = 2,
    parameter int N_DNBUF  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enable,
    input  logic [1:0]                        mode,
    input  logic [W_PW:0]                     pic_width,
    input  logic [W_PH:0]                     pic_height,
    input  logic [15:0]                       restart_interval,
    input  logic                              frame_start,
    input  logic                              strip_ready,
    input  logic                              mcu_done,
    input  logic                              dn_release,
    output logic                              mcu_go,
    output logic [W_PW-3:0]                   mcu_col,
    output logic [W_PH-3:0]                   mcu_row,
    output logic                              last_in_row,
    output logic                              last_in_pic,
    output logic                              restart_f,
    output logic [2:0]                        rst_idx,
    output logic                              frame_done,
    output logic                              err_overrun,
    output logic                              err_geom,
    output logic                              err_abort,
    output logic [1:0]                        dbg_state,
    output logic [$clog2(N_STRIPS+1)-1:0]     dbg_strips,
    output logic [$clog2(N_DNBUF+1)-1:0]      dbg_credits
);

    localparam int CW  = W_PW - 1;   // column count (one more bit than the column index)
    localparam int RW  = W_PH - 1;
    localparam int PCW = W_PW - 2;
    localparam int PRW = W_PH - 2;
    localparam int SW  = $clog2(N_STRIPS + 1);
    localparam int DW  = $clog2(N_DNBUF + 1);
    localparam logic [SW-1:0] STRIPS_MAX = SW'(N_STRIPS);
    localparam logic [DW-1:0] DN_MAX     = DW'(N_DNBUF);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_BUSY = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cols_q, cols_d, cols_new;
    logic [RW-1:0]   rows_q, rows_d, rows_new;
    logic            geom_bad_q, geom_bad_d;
    logic [PCW-1:0]  col_q, col_d;
    logic [PRW-1:0]  row_q, row_d;
    logic [SW-1:0]   strips_q, strips_d;
    logic [DW-1:0]   credits_q, credits_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [2:0]      rst_idx_q, rst_idx_d;
    logic            abort_q, abort_d;
    logic            mcu_go_q, mcu_go_d;
    logic [PCW-1:0]  mcu_col_q, mcu_col_d;
    logic [PRW-1:0]  mcu_row_q, mcu_row_d;
    logic            lir_q, lir_d, lip_q, lip_d;
    logic            restart_f_q, restart_f_d;
    logic [2:0]      rst_idx_o_q, rst_idx_o_d;
    logic            frame_done_q, frame_done_d;
    logic            err_overrun_q, err_overrun_d;
    logic            err_geom_q, err_geom_d;
    logic            err_abort_q, err_abort_d;

    logic [W_PW+1:0] w_sum;
    logic [W_PH+1:0] h_sum;
    logic            geom_ok, at_last_col, at_last_row;
    logic            launch, done, aborting, adv, row_end, clear_run;

    always_comb begin
        w_sum = {1'b0, pic_width} + ((mode == 2'd0) ? (W_PW+2)'(7) : (W_PW+2)'(15));
        h_sum = {1'b0, pic_height} + ((mode == 2'd2) ? (W_PH+2)'(15) : (W_PH+2)'(7));
        cols_new = (mode == 2'd0) ? CW'(w_sum >> 3) : CW'(w_sum >> 4);
        rows_new = (mode == 2'd2) ? RW'(h_sum >> 4) : RW'(h_sum >> 3);
    end

    assign geom_ok     = (mode != 2'd3) && (pic_width != '0) && (pic_height != '0);
    assign at_last_col = ({1'b0, col_q} == cols_q - CW'(1));
    assign at_last_row = ({1'b0, row_q} == rows_q - RW'(1));
    assign launch      = (state_q == S_WAIT) && enable && (strips_q != '0) && (credits_q != '0)
                         && !frame_start;
    assign done        = (state_q == S_BUSY) && mcu_done;
    assign aborting    = abort_q || frame_start;
    assign adv         = done && !aborting;
    assign row_end     = adv && at_last_col;
    assign clear_run   = frame_start && (state_q != S_IDLE);

    always_comb begin
        state_d       = state_q;
        cols_d        = cols_q;
        rows_d        = rows_q;
        geom_bad_d    = geom_bad_q;
        col_d         = col_q;
        row_d         = row_q;
        strips_d      = strips_q;
        credits_d     = credits_q;
        cnt_d         = cnt_q;
        rst_idx_d     = rst_idx_q;
        abort_d       = abort_q;
        mcu_go_d      = 1'b0;
        mcu_col_d     = mcu_col_q;
        mcu_row_d     = mcu_row_q;
        lir_d         = 1'b0;
        lip_d         = 1'b0;
        restart_f_d   = 1'b0;
        rst_idx_o_d   = 3'd0;
        frame_done_d  = 1'b0;
        err_overrun_d = err_overrun_q;
        err_geom_d    = err_geom_q;
        err_abort_d   = err_abort_q;

        if (launch) begin
            state_d   = S_BUSY;
            mcu_go_d  = 1'b1;
            mcu_col_d = col_q;
            mcu_row_d = row_q;
            lir_d     = at_last_col;
            lip_d     = at_last_col && at_last_row;
            // cnt_q is zero only before MCU 0, so a nonzero interval never marks the first MCU
            if ((restart_interval != 16'd0) && (cnt_q == restart_interval)) begin
                restart_f_d = 1'b1;
                rst_idx_o_d = rst_idx_q;
                rst_idx_d   = rst_idx_q + 3'd1;
                cnt_d       = 16'd1;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end

        if (done) begin
            if (aborting) begin
                abort_d = 1'b0;
                state_d = geom_bad_q ? S_IDLE : S_WAIT;
            end else if (at_last_col && at_last_row) begin
                state_d      = S_IDLE;
                frame_done_d = 1'b1;
            end else begin
                state_d = S_WAIT;
            end
        end

        if (adv) begin
            if (at_last_col) begin
                col_d = '0;
                row_d = at_last_row ? '0 : row_q + PRW'(1);
            end else begin
                col_d = col_q + PCW'(1);
            end
        end

        if (!clear_run) begin
            if (strip_ready && !row_end) begin
                if (strips_q == STRIPS_MAX) err_overrun_d = 1'b1;
                else                        strips_d = strips_q + SW'(1);
            end else if (row_end && !strip_ready && (strips_q != '0)) begin
                strips_d = strips_q - SW'(1);
            end
        end

        if (launch && !dn_release) begin
            credits_d = credits_q - DW'(1);
        end else if (!launch && dn_release && (credits_q != DN_MAX)) begin
            credits_d = credits_q + DW'(1);
        end

        if (frame_start) begin
            cols_d     = cols_new;
            rows_d     = rows_new;
            geom_bad_d = !geom_ok;
            col_d      = '0;
            row_d      = '0;
            cnt_d      = 16'd0;
            rst_idx_d  = 3'd0;
            if (!geom_ok) err_geom_d = 1'b1;
            if (clear_run) begin
                err_abort_d = 1'b1;
                strips_d    = '0;
            end
            case (state_q)
                S_IDLE:  state_d = geom_ok ? S_WAIT : S_IDLE;
                S_WAIT:  state_d = geom_ok ? S_WAIT : S_IDLE;
                // an MCU is still in flight: its mcu_done closes the aborted frame
                S_BUSY: begin
                    abort_d = !mcu_done;
                    if (mcu_done) state_d = geom_ok ? S_WAIT : S_IDLE;
                    else          state_d = S_BUSY;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cols_q        <= '0;
            rows_q        <= '0;
            geom_bad_q    <= 1'b0;
            col_q         <= '0;
            row_q         <= '0;
            strips_q      <= '0;
            credits_q     <= DN_MAX;
            cnt_q         <= 16'd0;
            rst_idx_q     <= 3'd0;
            abort_q       <= 1'b0;
            mcu_go_q      <= 1'b0;
            mcu_col_q     <= '0;
            mcu_row_q     <= '0;
            lir_q         <= 1'b0;
            lip_q         <= 1'b0;
            restart_f_q   <= 1'b0;
            rst_idx_o_q   <= 3'd0;
            frame_done_q  <= 1'b0;
            err_overrun_q <= 1'b0;
            err_geom_q    <= 1'b0;
            err_abort_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cols_q        <= cols_d;
            rows_q        <= rows_d;
            geom_bad_q    <= geom_bad_d;
            col_q         <= col_d;
            row_q         <= row_d;
            strips_q      <= strips_d;
            credits_q     <= credits_d;
            cnt_q         <= cnt_d;
            rst_idx_q     <= rst_idx_d;
            abort_q       <= abort_d;
            mcu_go_q      <= mcu_go_d;
            mcu_col_q     <= mcu_col_d;
            mcu_row_q     <= mcu_row_d;
            lir_q         <= lir_d;
            lip_q         <= lip_d;
            restart_f_q   <= restart_f_d;
            rst_idx_o_q   <= rst_idx_o_d;
            frame_done_q  <= frame_done_d;
            err_overrun_q <= err_overrun_d;
            err_geom_q    <= err_geom_d;
            err_abort_q   <= err_abort_d;
        end
    end

    assign mcu_go      = mcu_go_q;
    assign mcu_col     = mcu_col_q;
    assign mcu_row     = mcu_row_q;
    assign last_in_row = lir_q;
    assign last_in_pic = lip_q;
    assign restart_f   = restart_f_q;
    assign rst_idx     = rst_idx_o_q;
    assign frame_done  = frame_done_q;
    assign err_overrun = err_overrun_q;
    assign err_geom    = err_geom_q;
    assign err_abort   = err_abort_q;
    assign dbg_state   = state_q;
    assign dbg_strips  = strips_q;
    assign dbg_credits = credits_q;

endmodule

// File: tb/tb_mcu_scheduler.sv
// Bench for mcu_scheduler: a frame table walked by a responsive engine/camera model, plus
// hand sequences for backpressure, overrun, geometry errors, abort and mid-frame reset.
module tb_mcu_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [11:0] pic_width = 12'd32;
    logic [10:0] pic_height = 11'd16;
    logic [15:0] restart_interval = 16'd0;
    logic        frame_start = 1'b0;
    logic        strip_ready = 1'b0;
    logic        mcu_done = 1'b0;
    logic        dn_release = 1'b0;
    logic        mcu_go;
    logic [8:0]  mcu_col;
    logic [7:0]  mcu_row;
    logic        last_in_row, last_in_pic, restart_f;
    logic [2:0]  rst_idx;
    logic        frame_done, err_overrun, err_geom, err_abort;
    logic [1:0]  dbg_state;
    logic [1:0]  dbg_strips;
    logic [2:0]  dbg_credits;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_BUSY = 2'd2;

    mcu_scheduler dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode),
        .pic_width(pic_width), .pic_height(pic_height), .restart_interval(restart_interval),
        .frame_start(frame_start), .strip_ready(strip_ready), .mcu_done(mcu_done),
        .dn_release(dn_release), .mcu_go(mcu_go), .mcu_col(mcu_col), .mcu_row(mcu_row),
        .last_in_row(last_in_row), .last_in_pic(last_in_pic), .restart_f(restart_f),
        .rst_idx(rst_idx), .frame_done(frame_done), .err_overrun(err_overrun),
        .err_geom(err_geom), .err_abort(err_abort), .dbg_state(dbg_state),
        .dbg_strips(dbg_strips), .dbg_credits(dbg_credits)
    );

    // clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  mode;
        logic [11:0] w;
        logic [10:0] h;
        logic [15:0] ri;
        int          cols;
        int          rows;
    } frame_vec_t;

    frame_vec_t  vecs[7];
    logic [22:0] exp_q[$];
    int          n_pass = 0;
    int          n_total = 0;

    function automatic logic [22:0] pack(input logic [8:0] c, input logic [7:0] r,
                                         input logic lr, input logic lp,
                                         input logic rf, input logic [2:0] ix);
        return {c, r, lr, lp, rf, ix};
    endfunction

    function automatic logic [22:0] dut_word();
        return pack(mcu_col, mcu_row, last_in_row, last_in_pic, restart_f,
                    restart_f ? rst_idx : 3'd0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // scoreboard model: MCU i of a cols x rows frame
    task automatic push_range(input int cols, input int rows, input int ri,
                              input int from, input int to);
        int c, r;
        logic rf;
        logic [2:0] ix;
        for (int i = from; i <= to; i++) begin
            c = i % cols;
            r = i / cols;
            rf = 1'b0;
            ix = 3'd0;
            if (ri != 0) begin
                if ((i != 0) && (i % ri == 0)) begin
                    rf = 1'b1;
                    ix = 3'((i / ri - 1) % 8);
                end
            end
            exp_q.push_back(pack(9'(c), 8'(r), c == cols - 1, i == cols * rows - 1, rf, ix));
        end
    endtask

    // driver tasks
    task automatic pulse_fs();
        @(negedge clk); frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
    endtask

    task automatic pulse_strip();
        @(negedge clk); strip_ready = 1'b1;
        @(negedge clk); strip_ready = 1'b0;
    endtask

    task automatic pulse_rel();
        @(negedge clk); dn_release = 1'b1;
        @(negedge clk); dn_release = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_geom(input logic [1:0] m, input logic [11:0] w,
                            input logic [10:0] h, input logic [15:0] ri);
        mode = m; pic_width = w; pic_height = h; restart_interval = ri;
    endtask

    task automatic idle_count(input int n, output int gos, output int dones);
        gos = 0; dones = 0;
        repeat (n) begin
            @(negedge clk);
            if (mcu_go) gos++;
            if (frame_done) dones++;
        end
    endtask

    // engine/camera model: answers each mcu_go with mcu_done, optionally releases a slot and
    // supplies the next strip at each row end; compares every mcu_go against the scoreboard
    task automatic run_frame(input int n, input int cols, input int start_idx,
                             input bit give_strips, input bit give_rel, input int stop_go,
                             input int max_cyc, output int gos, output int first_lat,
                             output int dones);
        int idx, cyc;
        logic [22:0] act_v, exp_v;
        gos = 0; first_lat = -1; dones = 0; cyc = 0; idx = start_idx;
        while (dones == 0 && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            mcu_done = 1'b0; dn_release = 1'b0; strip_ready = 1'b0;
            if (frame_done) dones++;
            if (mcu_go) begin
                gos++;
                if (first_lat < 0) first_lat = cyc;
                act_v = dut_word();
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_go", 32'(act_v), 32'h0dead);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("sb_mcu", 32'(act_v), 32'(exp_v));
                end
                if (gos >= stop_go) return;
                mcu_done = 1'b1;
                if (give_rel) dn_release = 1'b1;
                if (give_strips && (idx % cols == cols - 1) && (idx != n - 1)) strip_ready = 1'b1;
                idx++;
            end
        end
        @(negedge clk);
        mcu_done = 1'b0; dn_release = 1'b0; strip_ready = 1'b0;
    endtask

    initial begin
        int gos, lat, dones, extra;

        vecs[0] = '{2'd0, 12'd32,  11'd16, 16'd0, 4, 2};
        vecs[1] = '{2'd2, 12'd40,  11'd20, 16'd0, 3, 2};
        vecs[2] = '{2'd1, 12'd64,  11'd16, 16'd3, 4, 2};
        vecs[3] = '{2'd0, 12'd17,  11'd9,  16'd2, 3, 2};
        vecs[4] = '{2'd2, 12'd16,  11'd16, 16'd1, 1, 1};
        vecs[5] = '{2'd1, 12'd100, 11'd30, 16'd5, 7, 4};
        vecs[6] = '{2'd0, 12'd40,  11'd16, 16'd1, 5, 2};

        // reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mcu_word", 32'(dut_word()), 0);
        check("rst_go", 32'(mcu_go), 0);
        check("rst_flags", 32'({frame_done, err_overrun, err_geom, err_abort}), 0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_credits", 32'(dbg_credits), 4);
        check("rst_strips", 32'(dbg_strips), 0);

        // enable low holds the first MCU back
        enable = 1'b0;
        set_geom(2'd0, 12'd32, 11'd16, 16'd0);
        pulse_strip();
        pulse_fs();
        idle_count($urandom_range(5, 12), gos, dones);
        check("enable_low_gos", gos, 0);
        check("enable_low_state", 32'(dbg_state), 32'(ST_WAIT));
        push_range(4, 2, 0, 0, 7);
        enable = 1'b1;
        run_frame(8, 4, 0, 1'b1, 1'b1, 999, 200, gos, lat, dones);
        check("enable_frame_gos", gos, 8);
        check("enable_frame_done", dones, 1);

        // frame table
        for (int v = 0; v < 7; v++) begin
            set_geom(vecs[v].mode, vecs[v].w, vecs[v].h, vecs[v].ri);
            push_range(vecs[v].cols, vecs[v].rows, int'(vecs[v].ri), 0,
                       vecs[v].cols * vecs[v].rows - 1);
            pulse_strip();
            pulse_fs();
            run_frame(vecs[v].cols * vecs[v].rows, vecs[v].cols, 0, 1'b1, 1'b1, 999, 500,
                      gos, lat, dones);
            check("tbl_gos", gos, vecs[v].cols * vecs[v].rows);
            check("tbl_frame_done", dones, 1);
            idle_count(3, gos, extra);
            check("tbl_quiet_after", gos + extra, 0);
        end
        check("tbl_no_errors", 32'({err_overrun, err_geom, err_abort}), 0);
        check("tbl_idle", 32'(dbg_state), 32'(ST_IDLE));

        // backpressure: four slots, then one release frees the fifth MCU
        set_geom(2'd0, 12'd32, 11'd16, 16'd0);
        push_range(4, 2, 0, 0, 7);
        pulse_strip();
        pulse_strip();
        pulse_fs();
        run_frame(8, 4, 0, 1'b0, 1'b0, 999, 30, gos, lat, dones);
        check("bp_gos_stalled", gos, 4);
        check("bp_credits_zero", 32'(dbg_credits), 0);
        check("bp_state_wait", 32'(dbg_state), 32'(ST_WAIT));
        @(negedge clk); dn_release = 1'b1;
        run_frame(8, 4, 4, 1'b0, 1'b1, 999, 200, gos, lat, dones);
        check("bp_release_latency", 32'((lat >= 1) && (lat <= 2)), 1);
        check("bp_rest_gos", gos, 4);
        check("bp_frame_done", dones, 1);
        repeat (3) pulse_rel();
        check("bp_credits_full", 32'(dbg_credits), 4);
        pulse_rel();
        check("bp_credits_sat", 32'(dbg_credits), 4);

        // strip overrun, counted while idle
        do_reset();
        pulse_strip();
        pulse_strip();
        check("ovr_not_yet", 32'(err_overrun), 0);
        pulse_strip();
        check("ovr_strips", 32'(dbg_strips), 2);
        check("ovr_flag", 32'(err_overrun), 1);

        // geometry errors
        do_reset();
        set_geom(2'd3, 12'd32, 11'd16, 16'd0);
        pulse_strip();
        pulse_fs();
        idle_count(6, gos, dones);
        check("geom_mode3_flag", 32'(err_geom), 1);
        check("geom_mode3_idle", 32'(dbg_state), 32'(ST_IDLE));
        check("geom_mode3_gos", gos, 0);
        do_reset();
        set_geom(2'd0, 12'd0, 11'd16, 16'd0);
        pulse_fs();
        check("geom_w0_flag", 32'(err_geom), 1);
        check("geom_w0_idle", 32'(dbg_state), 32'(ST_IDLE));

        // abort while the MCU at (2,0) is in flight
        do_reset();
        set_geom(2'd0, 12'd32, 11'd16, 16'd0);
        push_range(4, 2, 0, 0, 2);
        pulse_strip();
        pulse_fs();
        run_frame(8, 4, 0, 1'b1, 1'b1, 3, 50, gos, lat, dones);
        check("abort_pre_gos", gos, 3);
        pulse_fs();
        check("abort_flag", 32'(err_abort), 1);
        check("abort_still_busy", 32'(dbg_state), 32'(ST_BUSY));
        check("abort_strips_clr", 32'(dbg_strips), 0);
        mcu_done = 1'b1;
        @(negedge clk); mcu_done = 1'b0;
        check("abort_to_wait", 32'(dbg_state), 32'(ST_WAIT));
        idle_count(5, gos, dones);
        check("abort_no_go_wo_strip", gos + dones, 0);
        push_range(4, 2, 0, 0, 7);
        pulse_strip();
        run_frame(8, 4, 0, 1'b1, 1'b1, 999, 200, gos, lat, dones);
        check("abort_new_gos", gos, 8);
        check("abort_new_done", dones, 1);

        // reset in the middle of a frame
        do_reset();
        set_geom(2'd0, 12'd32, 11'd16, 16'd0);
        push_range(4, 2, 0, 0, 1);
        pulse_strip();
        pulse_fs();
        run_frame(8, 4, 0, 1'b1, 1'b1, 2, 50, gos, lat, dones);
        check("midrst_pre_gos", gos, 2);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_word", 32'(dut_word()), 0);
        check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("midrst_credits", 32'(dbg_credits), 4);
        check("midrst_strips", 32'(dbg_strips), 0);
        rst = 1'b0;
        mcu_done = 1'b1;
        @(negedge clk); mcu_done = 1'b0;
        idle_count(6, gos, dones);
        check("midrst_no_done", dones, 0);
        check("midrst_no_go", gos, 0);

        check("sb_queue_empty", exp_q.size(), 0);

        // final report
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mcu_scheduler.md
MCU_SCHEDULER -- requirements
Module: mcu_scheduler

Interface
REQ-001 SHALL have parameter W_PW, 11: picture width field is W_PW+1 bits.
REQ-002 SHALL have parameter W_PH, 10: picture height field is W_PH+1 bits.
REQ-003 SHALL have parameter N_STRIPS, 2: number of MCU-row strips the camera buffer holds.
REQ-004 SHALL have parameter N_DNBUF, 4: number of downstream (fdct/ee) buffer slots.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port enable, input, 1: when low, no new mcu_go is issued.
REQ-008 SHALL have port mode, input, 2: 0=444 (MCU 8x8), 1=422 (16x8), 2=420 (16x16), 3=reserved.
REQ-009 SHALL have port pic_width, input, W_PW+1: picture width in pixels.
REQ-010 SHALL have port pic_height, input, W_PH+1: picture height in pixels.
REQ-011 SHALL have port restart_interval, input, 16: MCUs per restart interval; 0 disables restart markers.
REQ-012 SHALL have port frame_start, input, 1: one-cycle pulse at the start of a new picture.
REQ-013 SHALL have port strip_ready, input, 1: one-cycle pulse when the camera completes one MCU-row strip.
REQ-014 SHALL have port mcu_done, input, 1: one-cycle pulse when the engine finishes the current MCU.
REQ-015 SHALL have port dn_release, input, 1: one-cycle pulse when one downstream slot is freed.
REQ-016 SHALL have port mcu_go, output, 1: one-cycle MCU start pulse.
REQ-017 SHALL have ports mcu_col and mcu_row, outputs, W_PW-2 and W_PH-2: position of the MCU, valid with mcu_go.
REQ-018 SHALL have ports last_in_row and last_in_pic, outputs, 1: flags valid with mcu_go.
REQ-019 SHALL have ports restart_f, output, 1 and rst_idx, output, 3: restart marker request and RSTm index, valid with mcu_go.
REQ-020 SHALL have port frame_done, output, 1: one-cycle pulse after the last MCU's mcu_done.
REQ-021 SHALL have ports err_overrun, err_geom and err_abort, outputs, 1 each: sticky error flags, cleared only by rst.

Function
REQ-022 On frame_start, geometry SHALL be latched:
- mcu_w = 8 (mode 0) or 16 (otherwise); mcu_h = 16 (mode 2) or 8 (otherwise).
- cols = ceil(pic_width/mcu_w); rows = ceil(pic_height/mcu_h). Partial MCUs are counted.
REQ-023 If mode==3, width==0 or height==0 at latch, err_geom SHALL set and the FSM SHALL stay IDLE for that frame.
REQ-024 FSM states SHALL be IDLE, WAIT, BUSY:
- IDLE->WAIT on a valid frame_start.
- WAIT->BUSY when enable && strips!=0 && dn_credits!=0; mcu_go pulses the same cycle, and position/flags are registered outputs.
- BUSY->WAIT on mcu_done when the MCU is not the last in the picture.
- BUSY->IDLE on mcu_done of the last MCU, with frame_done pulsing 1 cycle later.
REQ-025 Position SHALL advance on mcu_done: col+1; at col==cols-1, col=0 and row+1. Row SHALL wrap to 0 after the last row.
REQ-026 Strip counter SHALL cover 0..N_STRIPS:
- +1 on strip_ready.
- -1 on mcu_done of the last MCU in a row.
- Simultaneous inc and dec: unchanged.
- strip_ready at N_STRIPS with no dec: counter saturates and err_overrun sets.
REQ-027 dn_credits SHALL reset to N_DNBUF, -1 on mcu_go, +1 on dn_release; simultaneous events leave it unchanged. It SHALL saturate at N_DNBUF, and a release at full is ignored.
REQ-028 Restart handling, when restart_interval!=0:
- An MCU counter counts issued MCUs.
- restart_f SHALL assert with the mcu_go of MCU number k*restart_interval (k>=1, 0-based MCU index) and reset the count.
- rst_idx SHALL increment modulo 8 after each marker and reset to 0 on frame_start.
- No marker is generated on MCU 0.
REQ-029 frame_start while in WAIT or BUSY SHALL set err_abort and reload geometry.
- Position, strips, MCU count and rst_idx SHALL clear.
- In BUSY, the FSM SHALL wait for the outstanding mcu_done, which then returns it to WAIT without advancing position.
REQ-030 strip_ready in IDLE SHALL still count.
REQ-031 Deasserting enable SHALL only block new mcu_go; it SHALL not abort BUSY.

Reset
REQ-032 On rst:
- FSM SHALL go to IDLE.
- Position, strips, MCU count and rst_idx SHALL be 0; dn_credits SHALL be N_DNBUF.
- All outputs SHALL be 0, including the error flags.
- rst asserted mid-frame SHALL drop all in-flight state with no frame_done.

Verification
REQ-033 Scenario 444 basic: mode0, 32x16, RI=0, one strip_ready per row, immediate mcu_done -> 8 mcu_go with (col,row) (0,0)..(3,1), last_in_row at cols 3, last_in_pic on the 8th, one frame_done.
REQ-034 Scenario 420 partial MCU: mode2, 40x20 -> cols=3, rows=2, 6 MCUs.
REQ-035 Scenario backpressure: N_DNBUF=4, no dn_release -> exactly 4 mcu_go; one dn_release -> 5th mcu_go within 2 cycles.
REQ-036 Scenario restart: RI=3, 8 MCUs -> restart_f on MCUs 3 and 6 with rst_idx 0 then 1.
REQ-037 Scenario overrun: N_STRIPS=2, 3 strip_ready with no MCU issued -> strips=2, err_overrun=1.
REQ-038 Scenario abort: frame_start during BUSY at (2,0) -> err_abort=1; after mcu_done, the next mcu_go is (0,0).
